fpu_issue_ctrl: RTL

Sequencer and write-port arbiter for the multi-cycle floating-point datapath of the MIPS core. Accepts one FP arithmetic instruction at a time from the op decoder, latches its operands, and drives the shared FPU for a fixed op-dependent latency. It writes the result back to the FP register file through a write port shared with integer-side moves (mtc1/lwc1). It raises `stall` to the PC/pipeline on structural and RAW hazards against the pending destination.

---
 rtl/fpu_ctrl_pkg.sv | 22 ++
 rtl/fpu_lat_counter.sv | 29 ++
 rtl/fpu_issue_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fpu_ctrl_pkg.sv
// Shared encodings and default latencies for the FP issue controller.
package fpu_ctrl_pkg;

  typedef enum logic [1:0] {
    FOP_ADD = 2'd0,
    FOP_SUB = 2'd1,
    FOP_MUL = 2'd2,
    FOP_DIV = 2'd3
  } fop_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWb   = 2'd2
  } state_e;

  localparam int unsigned ADD_LAT = 2;
  localparam int unsigned MUL_LAT = 3;
  localparam int unsigned DIV_LAT = 12;
  localparam int unsigned CntW    = 4;

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter timing the FPU latency; saturates at zero.
module fpu_lat_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_value_i,
  input  logic             dec_i,
  output logic [Width-1:0] value_o,
  output logic             zero_o
);

  logic [Width-1:0] value_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= load_value_i;
    end else if (dec_i && (value_q != '0)) begin
      value_q <= value_q - 1'b1;
    end
  end

  assign value_o = value_q;
  assign zero_o  = (value_q == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// FP op sequencer and shared FP regfile write-port arbiter.
// Optional feature: define FPU_DIV_EN to accept DIV; otherwise DIV is rejected via illegal_op_o.
module fpu_issue_ctrl
  import fpu_ctrl_pkg::*;
#(
  parameter int unsigned AddLat = ADD_LAT,
  parameter int unsigned MulLat = MUL_LAT,
  parameter int unsigned DivLat = DIV_LAT
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        issue_valid_i,
  input  logic [1:0]  issue_op_i,
  input  logic [4:0]  issue_fd_i,
  input  logic [31:0] issue_a_i,
  input  logic [31:0] issue_b_i,
  input  logic        src_valid_i,
  input  logic [4:0]  src_fs_i,
  input  logic [4:0]  src_ft_i,
  input  logic        int_we_i,
  input  logic [4:0]  int_waddr_i,
  input  logic [31:0] int_wdata_i,
  input  logic [31:0] fpu_result_i,
  output logic        issue_ready_o,
  output logic        stall_o,
  output logic        fpu_start_o,
  output logic [1:0]  fpu_op_o,
  output logic [31:0] fpu_a_o,
  output logic [31:0] fpu_b_o,
  output logic        fp_we_o,
  output logic [4:0]  fp_waddr_o,
  output logic [31:0] fp_wdata_o,
  output logic        illegal_op_o
);

  state_e          state_q;
  logic [1:0]      op_q;
  logic [4:0]      fd_q;
  logic [31:0]     a_q, b_q, res_q;
  logic            start_q, illegal_q, squash_q;
  logic            op_ok, accept, busy, waw_hit, fpu_wr;
  logic [CntW-1:0] lat_m1, cnt_value;
  logic            cnt_zero;
  logic            unused_cnt;

  // Counter is loaded with LAT-1 so EXEC lasts exactly LAT cycles.
  always_comb begin
    lat_m1 = CntW'(AddLat - 1);
    unique case (issue_op_i)
      FOP_ADD, FOP_SUB: lat_m1 = CntW'(AddLat - 1);
      FOP_MUL:          lat_m1 = CntW'(MulLat - 1);
      default:          lat_m1 = CntW'(DivLat - 1);
    endcase
  end

`ifdef FPU_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = (issue_op_i != FOP_DIV);
`endif

  assign busy    = (state_q != StIdle);
  assign accept  = (state_q == StIdle) && issue_valid_i && op_ok;
  assign waw_hit = busy && int_we_i && (int_waddr_i == fd_q);
  assign fpu_wr  = (state_q == StWb) && !int_we_i;

  fpu_lat_counter #(
    .Width (CntW)
  ) u_lat_counter (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (accept),
    .load_value_i (lat_m1),
    .dec_i        (state_q == StExec),
    .value_o      (cnt_value),
    .zero_o       (cnt_zero)
  );

  assign unused_cnt = ^cnt_value;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      fd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
      squash_q  <= 1'b0;
    end else begin
      start_q   <= 1'b0;
      illegal_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          illegal_q <= issue_valid_i && !op_ok;
          if (accept) begin
            op_q     <= issue_op_i;
            fd_q     <= issue_fd_i;
            a_q      <= issue_a_i;
            b_q      <= issue_b_i;
            start_q  <= 1'b1;
            squash_q <= 1'b0;
            state_q  <= StExec;
          end
        end
        StExec: begin
          if (waw_hit) squash_q <= 1'b1;
          if (cnt_zero) begin
            res_q   <= fpu_result_i;
            state_q <= (squash_q || waw_hit) ? StIdle : StWb;
          end
        end
        StWb: begin
          // A same-cycle integer write to fd supersedes the FPU result.
          if (!int_we_i || waw_hit) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign issue_ready_o = (state_q == StIdle);
  assign fpu_start_o   = start_q;
  assign fpu_op_o      = op_q;
  assign fpu_a_o       = a_q;
  assign fpu_b_o       = b_q;
  assign illegal_op_o  = illegal_q;

  assign fp_we_o    = fpu_wr || int_we_i;
  assign fp_waddr_o = fpu_wr ? fd_q : int_waddr_i;
  assign fp_wdata_o = fpu_wr ? res_q : int_wdata_i;

  assign stall_o = busy && (issue_valid_i ||
                   (src_valid_i && !squash_q && ((src_fs_i == fd_q) || (src_ft_i == fd_q))));

endmodule
